// File: rtl/tpu_sequencer.sv
// Program sequencer for the tiny TPU: fetches and decodes 16-bit instructions and
// drives the unified-buffer read port plus weight-FIFO / systolic-array handshakes.
module tpu_sequencer #(
  parameter int unsigned ARRAY_N = 2,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic               ub_rd_en,
  output logic [ADDR_W-1:0]  ub_addr,
  output logic               load_weight,
  input  logic               wt_ready,
  output logic               act_valid,
  input  logic               act_ready,
  output logic               weight_commit,
  input  logic               array_idle,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = 8;

  localparam logic [2:0] OpLoadAddr   = 3'b000;
  localparam logic [2:0] OpLoadWeight = 3'b001;
  localparam logic [2:0] OpCompute    = 3'b010;
  localparam logic [2:0] OpDrain      = 3'b011;
  localparam logic [2:0] OpHalt       = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StLoadW,
    StCompute,
    StDrain,
    StHalted
  } state_e;

  state_e             state_q;
  logic [IMEM_AW-1:0] pc_q;
  logic [ADDR_W-1:0]  base_q;
  logic [CntW-1:0]    cnt_q;
  logic [CntW-1:0]    len_q;
  logic               commit_q;

  logic [2:0]         opcode;
  logic [CntW-1:0]    operand_len;

  assign opcode      = imem_rdata[15:13];
  assign operand_len = imem_rdata[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      unique case (state_q)
        StIdle, StHalted: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: state_q <= StDecode;
        StDecode: begin
          // pc wraps naturally at 2^IMEM_AW; running off the end is not a halt
          pc_q <= pc_q + 1'b1;
          case (opcode)
            OpLoadAddr: begin
              base_q  <= imem_rdata[ADDR_W-1:0];
              state_q <= StFetch;
            end
            OpLoadWeight: begin
              cnt_q   <= '0;
              state_q <= StLoadW;
            end
            OpCompute: begin
              len_q   <= operand_len;
              cnt_q   <= '0;
              state_q <= (operand_len == '0) ? StFetch : StCompute;
            end
            OpDrain: state_q <= StDrain;
            OpHalt:  state_q <= StHalted;
            default: state_q <= StFetch;
          endcase
        end
        StLoadW: begin
          if (wt_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(ARRAY_N - 1)) begin
              state_q  <= StFetch;
              commit_q <= 1'b1;
            end
          end
        end
        StCompute: begin
          if (act_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) state_q <= StFetch;
          end
        end
        StDrain: begin
          if (array_idle) state_q <= StFetch;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_addr     = pc_q;
  assign load_weight   = (state_q == StLoadW);
  assign act_valid     = (state_q == StCompute);
  assign ub_rd_en      = load_weight | act_valid;
  // Address wraps silently modulo 2^ADDR_W
  assign ub_addr       = ub_rd_en ? (base_q + ADDR_W'(cnt_q)) : '0;
  assign weight_commit = commit_q;
  assign busy          = (state_q != StIdle) && (state_q != StHalted);
  assign done          = (state_q == StHalted);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: small programs with hand-computed addresses,
// handshake stalls, drain, NOP/start handling and mid-instruction reset.
module tb_tpu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        ub_rd_en;
  logic [12:0] ub_addr;
  logic        load_weight;
  logic        wt_ready;
  logic        act_valid;
  logic        act_ready;
  logic        weight_commit;
  logic        array_idle;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  int commit_cnt = 0;
  int rd_cnt     = 0;
  int excl_err   = 0;
  int c0;
  int r0;

  tpu_sequencer #(
    .ARRAY_N (2),
    .ADDR_W  (13),
    .IMEM_AW (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ub_rd_en      (ub_rd_en),
    .ub_addr       (ub_addr),
    .load_weight   (load_weight),
    .wt_ready      (wt_ready),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .weight_commit (weight_commit),
    .array_idle    (array_idle),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: one cycle of read latency
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  always @(negedge clk) begin
    if (weight_commit) commit_cnt++;
    if (ub_rd_en) rd_cnt++;
    if ((load_weight && act_valid) || (ub_rd_en != (load_weight || act_valid))) excl_err++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_prog(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2);
    mem[0] = i0;
    mem[1] = i1;
    mem[2] = i2;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rd(input string tag, input int budget);
    int i = 0;
    while (!ub_rd_en && i < budget) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(ub_rd_en), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (!done && i < budget) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    reset      = 1'b0;
    start      = 1'b0;
    wt_ready   = 1'b1;
    act_ready  = 1'b1;
    array_idle = 1'b1;
    tick();
    tick();
    check_eq("rst_rd_en", 32'(ub_rd_en), 32'd0);
    check_eq("rst_lw", 32'(load_weight), 32'd0);
    check_eq("rst_av", 32'(act_valid), 32'd0);
    check_eq("rst_commit", 32'(weight_commit), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_ub_addr", 32'(ub_addr), 32'd0);
    reset = 1'b1;
    tick();

    // Weight load at base 0x010, no stalls
    load_prog(16'h0010, 16'h2000, 16'hE000);
    c0 = commit_cnt;
    pulse_start();
    wait_rd("t1_rd_seen", 20);
    check_eq("t1_addr0", 32'(ub_addr), 32'h010);
    check_eq("t1_lw0", 32'(load_weight), 32'd1);
    check_eq("t1_av0", 32'(act_valid), 32'd0);
    tick();
    check_eq("t1_addr1", 32'(ub_addr), 32'h011);
    check_eq("t1_lw1", 32'(load_weight), 32'd1);
    tick();
    check_eq("t1_commit_hi", 32'(weight_commit), 32'd1);
    check_eq("t1_rd_off", 32'(ub_rd_en), 32'd0);
    tick();
    check_eq("t1_commit_lo", 32'(weight_commit), 32'd0);
    wait_done("t1_done", 20);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_pc", 32'(imem_addr), 32'd3);
    check_eq("t1_commit_cnt", 32'(commit_cnt - c0), 32'd1);

    // Same program, wt_ready pattern 1,0,0,1 across LOAD_W cycles
    c0 = commit_cnt;
    pulse_start();
    wait_rd("t2_rd_seen", 20);
    check_eq("t2_addr0", 32'(ub_addr), 32'h010);
    tick();
    check_eq("t2_addr1", 32'(ub_addr), 32'h011);
    wt_ready = 1'b0;
    tick();
    check_eq("t2_hold1", 32'(ub_addr), 32'h011);
    check_eq("t2_commit_stall", 32'(weight_commit), 32'd0);
    tick();
    check_eq("t2_hold2", 32'(ub_addr), 32'h011);
    check_eq("t2_lw_stall", 32'(load_weight), 32'd1);
    wt_ready = 1'b1;
    tick();
    check_eq("t2_commit_hi", 32'(weight_commit), 32'd1);
    check_eq("t2_rd_off", 32'(ub_rd_en), 32'd0);
    wait_done("t2_done", 20);
    check_eq("t2_commit_cnt", 32'(commit_cnt - c0), 32'd1);

    // Compute len=3 from base 0x1FFF, address wraps; one act_ready stall
    load_prog(16'h1FFF, 16'h4003, 16'hE000);
    pulse_start();
    wait_rd("t3_rd_seen", 20);
    check_eq("t3_addr0", 32'(ub_addr), 32'h1FFF);
    check_eq("t3_av0", 32'(act_valid), 32'd1);
    check_eq("t3_lw0", 32'(load_weight), 32'd0);
    tick();
    check_eq("t3_addr1", 32'(ub_addr), 32'h0000);
    act_ready = 1'b0;
    tick();
    check_eq("t3_addr1_hold", 32'(ub_addr), 32'h0000);
    act_ready = 1'b1;
    tick();
    check_eq("t3_addr2", 32'(ub_addr), 32'h0001);
    check_eq("t3_av2", 32'(act_valid), 32'd1);
    tick();
    check_eq("t3_rd_off", 32'(ub_rd_en), 32'd0);
    wait_done("t3_done", 20);
    check_eq("t3_pc", 32'(imem_addr), 32'd3);

    // COMPUTE len=0 is a no-op, then DRAIN held by array_idle=0
    load_prog(16'h4000, 16'h6000, 16'hE000);
    array_idle = 1'b0;
    r0 = rd_cnt;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t4_busy", 32'(busy), 32'd1);
    end
    check_eq("t4_pc_drain", 32'(imem_addr), 32'd2);
    check_eq("t4_done_drain", 32'(done), 32'd0);
    array_idle = 1'b1;
    tick();
    check_eq("t4_busy_exit", 32'(busy), 32'd1);
    tick();
    tick();
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_pc", 32'(imem_addr), 32'd3);
    check_eq("t4_no_reads", 32'(rd_cnt - r0), 32'd0);

    // Unknown opcode 101 is a NOP; start ignored while busy; restart from HALTED
    load_prog(16'hA000, 16'hE000, 16'hE000);
    pulse_start();
    start = 1'b1;
    tick();
    check_eq("t5_pc_decode", 32'(imem_addr), 32'd0);
    start = 1'b0;
    tick();
    check_eq("t5_pc_fetch", 32'(imem_addr), 32'd1);
    tick();
    tick();
    check_eq("t5_done", 32'(done), 32'd1);
    check_eq("t5_pc", 32'(imem_addr), 32'd2);
    pulse_start();
    check_eq("t5_restart_pc", 32'(imem_addr), 32'd0);
    check_eq("t5_restart_busy", 32'(busy), 32'd1);
    wait_done("t5_redone", 20);
    check_eq("t5_repc", 32'(imem_addr), 32'd2);

    // base_addr persists (0x1FFF), then reset mid LOAD_W after one row
    load_prog(16'h2000, 16'hE000, 16'hE000);
    c0 = commit_cnt;
    pulse_start();
    wait_rd("t6_rd_seen", 20);
    check_eq("t6_addr0", 32'(ub_addr), 32'h1FFF);
    tick();
    check_eq("t6_addr1", 32'(ub_addr), 32'h0000);
    check_eq("t6_lw1", 32'(load_weight), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_rd_en", 32'(ub_rd_en), 32'd0);
    check_eq("t6_rst_lw", 32'(load_weight), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_pc", 32'(imem_addr), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_eq("t6_no_commit", 32'(commit_cnt - c0), 32'd0);
    check_eq("t6_idle_busy", 32'(busy), 32'd0);
    check_eq("t6_idle_done", 32'(done), 32'd0);

    // Reset cleared base_addr
    pulse_start();
    wait_rd("t7_rd_seen", 20);
    check_eq("t7_addr0", 32'(ub_addr), 32'h0000);
    wait_done("t7_done", 20);
    check_eq("excl_errors", 32'(excl_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Program sequencer for the tiny TPU: fetches 16-bit instructions from a synchronous instruction memory, decodes them, and drives the unified-buffer read port and systolic-array control.
- Encoding: opcode in bits [15:13], operand in bits [12:0]. LOAD_ADDR and LOAD_WEIGHT keep their existing encodings. COMPUTE, DRAIN and HALT are added.
- Sits between instruction memory and the unified buffer / weight FIFO / systolic array.

Parameters:
- ARRAY_N, 2, systolic array dimension; weight rows per LOAD_WEIGHT.
- ADDR_W, 13, unified-buffer address width; must equal operand width.
- IMEM_AW, 8, instruction memory address width.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- start  input  1  begin execution at pc=0; honoured only in IDLE or HALTED.
- imem_addr  output  IMEM_AW  instruction address (equals pc).
- imem_rdata  input  16  instruction word; valid one cycle after imem_addr is presented.
- ub_rd_en  output  1  unified-buffer read request.
- ub_addr  output  ADDR_W  unified-buffer read address.
- load_weight  output  1  current ub read is a weight row, destined for the weight FIFO.
- wt_ready  input  1  weight FIFO accepts a row.
- act_valid  output  1  current ub read is an activation vector.
- act_ready  input  1  array accepts an activation vector.
- weight_commit  output  1  one-cycle pulse: full weight tile loaded.
- array_idle  input  1  systolic array has no data in flight.
- busy  output  1  high in every state except IDLE and HALTED.
- done  output  1  high while in HALTED.

Behaviour:
- Reset (async, reset==0): state=IDLE, pc=0, base_addr=0, cnt=0, len=0. All outputs 0; imem_addr=0. Reset mid-instruction abandons it, with no partial commit.
- States: IDLE, FETCH, DECODE, LOAD_W, COMPUTE, DRAIN, HALTED.
- IDLE / HALTED: on start=1, pc<=0, go to FETCH.
- FETCH: imem_addr=pc; go to DECODE.
- DECODE: sample imem_rdata; pc<=pc+1, wrapping from 2^IMEM_AW-1 to 0 with no halt. Then dispatch on opcode:
  - 000 LOAD_ADDR: base_addr<=operand; go to FETCH (2 cycles per instruction).
  - 001 LOAD_WEIGHT: cnt<=0; go to LOAD_W.
  - 010 COMPUTE: len<=operand[7:0]; cnt<=0. If len==0, go to FETCH (no-op); else go to COMPUTE.
  - 011 DRAIN: go to DRAIN.
  - 111 HALT: go to HALTED.
  - All other opcodes: NOP, go to FETCH.
- LOAD_W:
  - Drive ub_rd_en=1, load_weight=1, ub_addr=base_addr+cnt (mod 2^ADDR_W).
  - Handshake completes when wt_ready=1; then cnt++.
  - When wt_ready=0, hold address and cnt.
  - On the handshake where cnt==ARRAY_N-1: go to FETCH, and assert weight_commit registered, high exactly the next cycle.
- COMPUTE:
  - Drive ub_rd_en=1, act_valid=1, ub_addr=base_addr+cnt (mod 2^ADDR_W).
  - Transfer on act_ready=1; stall on act_ready=0.
  - After the len-th transfer, go to FETCH.
- DRAIN: all request outputs 0; go to FETCH in the first cycle array_idle=1. If array_idle is already 1 on entry, DRAIN lasts exactly 1 cycle.
- Output exclusivity: ub_rd_en is 0 outside LOAD_W and COMPUTE. load_weight and act_valid are never high together.
- Address wrap: base_addr+cnt wraps silently; e.g. base 0x1FFF, ARRAY_N=2 reads 0x1FFF then 0x0000.
- start is ignored while busy=1.
- base_addr persists across instructions and across HALT/start. It is cleared only by reset.

Test Plan:
- Program {LOAD_ADDR 0x010, LOAD_WEIGHT, HALT}, wt_ready=1 -> ub_addr 0x010, 0x011 on consecutive cycles with load_weight=1; weight_commit pulses once; done=1; pc=3.
- Same program with wt_ready toggling 1,0,0,1 -> ub_addr holds 0x011 through the stall; exactly 2 handshakes; one weight_commit.
- {LOAD_ADDR 0x1FFF, COMPUTE len=3, HALT}, act_ready=1 -> ub_addr 0x1FFF, 0x0000, 0x0001 with act_valid=1; then HALTED.
- COMPUTE len=0, then DRAIN with array_idle low for 5 cycles -> no ub_rd_en; DRAIN holds 5 cycles, exits on array_idle=1; busy stays high.
- Unknown opcode 0b101, then HALT; start pulsed mid-run -> treated as NOP; start ignored while busy; re-start from HALTED refetches pc=0.
- reset asserted low mid-LOAD_W (after 1 of 2 rows) -> all outputs 0 immediately; no weight_commit; state IDLE after release.
